uart_led_ctrl: RTL and testbench

//  Parametrised UART command receiver for the RS232 LED demo.
//  - Receives 8-bit frames on RX with optional parity and error detection.
//  - Decodes ASCII commands to toggle or clear NUM_LEDS outputs.
//  - Optionally echoes each accepted byte on TX.

---
 rtl/uart_led_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_uart_led_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_led_ctrl.sv
// UART command receiver: toggles/clears LEDs from ASCII digits and echoes
// accepted bytes. Optional parity on both directions.
module uart_led_ctrl #(
  parameter int CLK_HZ   = 12000000,
  parameter int BAUD     = 9600,
  parameter int NUM_LEDS = 5,
  parameter int PARITY   = 0,
  parameter int ECHO     = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RX,
  output logic                TX,
  output logic [NUM_LEDS-1:0] LED,
  output logic                RX_VALID,
  output logic [7:0]          RX_DATA,
  output logic                FRAME_ERR,
  output logic                PARITY_ERR
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF   = CW'(DIV / 2);
  localparam logic [3:0]    TX_BITS_AFTER_START = (PARITY != 0) ? 4'd10 : 4'd9;

  function automatic logic par_of(input logic [7:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // Reset enters asynchronously but leaves on a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_int;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rst_sync_reg <= 2'b11;
    else     rst_sync_reg <= {rst_sync_reg[0], 1'b0};
  end
  assign rst_int = rst_sync_reg[1];

  logic sync1_reg, rxs_reg;

  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) begin
      sync1_reg <= 1'b1;
      rxs_reg   <= 1'b1;
    end else begin
      sync1_reg <= RX;
      rxs_reg   <= sync1_reg;
    end
  end

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } rx_state_t;

  rx_state_t      rx_state_reg;
  logic [CW-1:0]  rx_cnt_reg;
  logic [2:0]     rx_bit_reg;
  logic [7:0]     rx_shift_reg;
  logic           rx_par_reg;
  logic [7:0]     rx_data_reg;
  logic           rx_valid_reg, frame_err_reg, parity_err_reg;

  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) begin
      rx_state_reg   <= S_WAIT_IDLE;
      rx_cnt_reg     <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_par_reg     <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      case (rx_state_reg)
        S_WAIT_IDLE: if (rxs_reg) rx_state_reg <= S_IDLE;
        S_IDLE: begin
          if (!rxs_reg) begin
            rx_cnt_reg   <= HALF;
            rx_state_reg <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_reg != '0) rx_cnt_reg <= rx_cnt_reg - 1'b1;
          else if (rxs_reg) rx_state_reg <= S_IDLE;
          else begin
            rx_cnt_reg   <= DIV_M1;
            rx_bit_reg   <= '0;
            rx_state_reg <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_cnt_reg != '0) rx_cnt_reg <= rx_cnt_reg - 1'b1;
          else begin
            rx_shift_reg <= {rxs_reg, rx_shift_reg[7:1]};
            rx_cnt_reg   <= DIV_M1;
            rx_bit_reg   <= rx_bit_reg + 1'b1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (rx_cnt_reg != '0) rx_cnt_reg <= rx_cnt_reg - 1'b1;
          else begin
            rx_par_reg   <= rxs_reg;
            rx_cnt_reg   <= DIV_M1;
            rx_state_reg <= S_STOP;
          end
        end
        S_STOP: begin
          if (rx_cnt_reg != '0) rx_cnt_reg <= rx_cnt_reg - 1'b1;
          else if (!rxs_reg) begin
            frame_err_reg <= 1'b1;
            rx_state_reg  <= S_WAIT_IDLE;
          end else if ((PARITY != 0) && (rx_par_reg != par_of(rx_shift_reg))) begin
            parity_err_reg <= 1'b1;
            rx_state_reg   <= S_IDLE;
          end else begin
            rx_valid_reg <= 1'b1;
            rx_data_reg  <= rx_shift_reg;
            rx_state_reg <= S_IDLE;
          end
        end
        default: rx_state_reg <= S_WAIT_IDLE;
      endcase
    end
  end

  assign RX_VALID   = rx_valid_reg;
  assign RX_DATA    = rx_data_reg;
  assign FRAME_ERR  = frame_err_reg;
  assign PARITY_ERR = parity_err_reg;

  // '1'+gi addresses LED[gi]; '0' clears everything.
  logic [NUM_LEDS-1:0] led_hit;
  logic [NUM_LEDS-1:0] led_reg;

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led_hit
    assign led_hit[gi] = (rx_data_reg == 8'(8'h31 + gi));
  end

  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) led_reg <= '0;
    else if (rx_valid_reg) begin
      if (rx_data_reg == 8'h30) led_reg <= '0;
      else                      led_reg <= led_reg ^ led_hit;
    end
  end
  assign LED = led_reg;

  typedef enum logic {T_IDLE, T_SHIFT} tx_state_t;

  tx_state_t     tx_state_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic [3:0]    tx_left_reg;
  logic [9:0]    tx_shift_reg;
  logic          tx_reg;
  logic [7:0]    hold_reg;
  logic          hold_full_reg;
  logic          tx_req, tx_done, tx_free;

  assign tx_req  = (ECHO != 0) && rx_valid_reg;
  assign tx_done = (tx_state_reg == T_SHIFT) && (tx_cnt_reg == '0) && (tx_left_reg == '0);
  assign tx_free = (tx_state_reg == T_IDLE) || tx_done;

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return (PARITY != 0) ? {1'b1, par_of(d), d} : {2'b11, d};
  endfunction

  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) begin
      tx_state_reg  <= T_IDLE;
      tx_cnt_reg    <= '0;
      tx_left_reg   <= '0;
      tx_shift_reg  <= '0;
      tx_reg        <= 1'b1;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else begin
      if (tx_state_reg == T_SHIFT) begin
        if (tx_cnt_reg != '0) tx_cnt_reg <= tx_cnt_reg - 1'b1;
        else if (tx_left_reg != '0) begin
          tx_reg       <= tx_shift_reg[0];
          tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
          tx_left_reg  <= tx_left_reg - 1'b1;
          tx_cnt_reg   <= DIV_M1;
        end else begin
          tx_state_reg <= T_IDLE;
        end
      end
      // Holding byte has priority; a new byte then takes its place.
      if (tx_free && (hold_full_reg || tx_req)) begin
        tx_state_reg <= T_SHIFT;
        tx_reg       <= 1'b0;
        tx_cnt_reg   <= DIV_M1;
        tx_left_reg  <= TX_BITS_AFTER_START;
        if (hold_full_reg) begin
          tx_shift_reg  <= frame_of(hold_reg);
          hold_full_reg <= tx_req;
          if (tx_req) hold_reg <= rx_data_reg;
        end else begin
          tx_shift_reg <= frame_of(rx_data_reg);
        end
      end else if (tx_req && !hold_full_reg) begin
        hold_reg      <= rx_data_reg;
        hold_full_reg <= 1'b1;
      end
    end
  end
  assign TX = tx_reg;

endmodule

// File: tb/tb_uart_led_ctrl.sv
// Randomised scoreboard bench for uart_led_ctrl (even parity, echo on, DIV = 16).
module tb_uart_led_ctrl;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 62500;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int NL     = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX  = 1'b1;
  logic          TX;
  logic [NL-1:0] LED;
  logic          RX_VALID, FRAME_ERR, PARITY_ERR;
  logic [7:0]    RX_DATA;

  uart_led_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_LEDS(NL), .PARITY(2), .ECHO(1)) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .TX(TX), .LED(LED), .RX_VALID(RX_VALID),
    .RX_DATA(RX_DATA), .FRAME_ERR(FRAME_ERR), .PARITY_ERR(PARITY_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            kind;   // 0 valid, 1 frame error, 2 parity error
    logic [7:0]    data;
    logic [NL-1:0] led;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] txq[$];
  int         checks = 0;
  int         errors = 0;
  int         rst_count = 0;
  logic [NL-1:0] led_model = '0;
  logic [7:0]    last_rx = 8'h00;
  logic          led_pending = 1'b0;
  logic [NL-1:0] led_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural model: what the line should cause, computed from the byte alone.
  task automatic expect_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    ev_t e;
    int  idx;
    if (stop_bad)     e.kind = 1;
    else if (par_bad) e.kind = 2;
    else begin
      e.kind  = 0;
      last_rx = b;
      idx     = int'(b) - 49;
      if (b == 8'h30) led_model = '0;
      else if (idx >= 0 && idx < NL) led_model = led_model ^ NL'(1 << idx);
      txq.push_back(b);
    end
    e.data = last_rx;
    e.led  = led_model;
    evq.push_back(e);
  endtask

  task automatic do_reset_checks();
    RST = 1'b1;
    #1;
    check("rst_led", 32'(LED), 32'h0);
    check("rst_tx", 32'(TX), 32'h1);
    check("rst_rxdata", 32'(RX_DATA), 32'h0);
    led_model = '0;
    last_rx = 8'h00;
    evq.delete();
    txq.delete();
    led_pending = 1'b0;
    rst_count++;
  endtask

  // rst_idx: frame bit index at which RST is raised (-1 = none); released mid stop bit.
  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                            input int rst_idx, input int gap_bits);
    logic [10:0] fr;
    bit in_rst;
    fr = {~stop_bad, (^b) ^ par_bad, b, 1'b0};
    in_rst = 1'b0;
    if (rst_idx < 0) expect_frame(b, par_bad, stop_bad);
    for (int k = 0; k < 11; k++) begin
      RX = fr[k];
      if (k == rst_idx || (in_rst && k == 10)) begin
        repeat (DIV / 2) @(negedge CLK);
        if (k == rst_idx) begin
          do_reset_checks();
          in_rst = 1'b1;
        end else RST = 1'b0;
        repeat (DIV - DIV / 2) @(negedge CLK);
      end else repeat (DIV) @(negedge CLK);
    end
    RX = 1'b1;
    repeat (gap_bits * DIV) @(negedge CLK);
  endtask

  task automatic drain();
    int n = 0;
    while ((evq.size() != 0 || txq.size() != 0) && n < 40 * 11 * DIV) begin
      @(negedge CLK);
      n++;
    end
    check("drain_evq", 32'(evq.size()), 32'h0);
    check("drain_txq", 32'(txq.size()), 32'h0);
  endtask

  // RX-side monitor: pulses and the LED state one cycle after RX_VALID.
  always @(negedge CLK) begin
    ev_t e;
    int  kind;
    if (led_pending) begin
      check("led", 32'(LED), 32'(led_exp));
      led_pending = 1'b0;
    end
    if (RX_VALID || FRAME_ERR || PARITY_ERR) begin
      check("one_pulse", 32'(RX_VALID) + 32'(FRAME_ERR) + 32'(PARITY_ERR), 32'h1);
      kind = RX_VALID ? 0 : (FRAME_ERR ? 1 : 2);
      if (evq.size() == 0) begin
        check("unexpected_pulse", 32'(kind), 32'hFFFF);
      end else begin
        e = evq.pop_front();
        check("pulse_kind", 32'(kind), 32'(e.kind));
        check("rx_data", 32'(RX_DATA), 32'(e.data));
        if (kind == 0) begin
          led_pending = 1'b1;
          led_exp = e.led;
        end
      end
    end
  end

  // TX-side monitor: decodes echo frames mid-bit.
  initial begin
    logic [7:0] d;
    logic p, s, st, exp;
    int r0;
    forever begin
      @(negedge CLK);
      if (TX === 1'b0) begin
        r0 = rst_count;
        repeat (DIV / 2) @(negedge CLK);
        st = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge CLK);
          d[i] = TX;
        end
        repeat (DIV) @(negedge CLK);
        p = TX;
        repeat (DIV) @(negedge CLK);
        s = TX;
        if (r0 == rst_count) begin
          if (txq.size() == 0) check("unexpected_tx", 32'(d), 32'hFFFF);
          else begin
            exp = 1'b0;
            exp = ^txq[0];
            check("tx_start", 32'(st), 32'h0);
            check("tx_data", 32'(d), 32'(txq[0]));
            check("tx_parity", 32'(p), 32'(exp));
            check("tx_stop", 32'(s), 32'h1);
            void'(txq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge CLK);
    check("rst_led", 32'(LED), 32'h0);
    check("rst_tx", 32'(TX), 32'h1);
    check("rst_rxdata", 32'(RX_DATA), 32'h0);
    check("rst_pulses", 32'(RX_VALID) + 32'(FRAME_ERR) + 32'(PARITY_ERR), 32'h0);
    RST = 1'b0;
    repeat (2 * DIV) @(negedge CLK);

    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 5; c++) send_frame(8'(8'h31 + c), 1'b0, 1'b0, -1, 2);
    send_frame(8'h33, 1'b0, 1'b0, -1, 2);
    send_frame(8'h30, 1'b0, 1'b0, -1, 2);
    send_frame(8'h31, 1'b0, 1'b1, -1, 2);   // bad stop bit
    send_frame(8'h32, 1'b0, 1'b0, -1, 2);
    send_frame(8'h31, 1'b1, 1'b0, -1, 2);   // bad parity
    send_frame(8'h31, 1'b0, 1'b0, -1, 2);
    for (int g = 0; g < 3; g++) begin
      RX = 1'b0;
      repeat ($urandom_range(1, DIV / 2 - 3)) @(negedge CLK);
      RX = 1'b1;
      repeat (2 * DIV) @(negedge CLK);
    end
    expect_frame(8'h00, 1'b0, 1'b1);        // long break ends in a frame error
    RX = 1'b0;
    repeat (300) @(negedge CLK);
    RX = 1'b1;
    repeat (2 * DIV) @(negedge CLK);
    send_frame(8'h34, 1'b0, 1'b0, -1, 2);
    drain();

    send_frame(8'h30, 1'b0, 1'b0, -1, 1);
    send_frame(8'h31, 1'b0, 1'b0, -1, 1);
    send_frame(8'h35, 1'b0, 1'b0, 5, 3);    // reset during data bit 4
    send_frame(8'h31, 1'b0, 1'b0, -1, 2);
    drain();

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      int e;
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h30 + $urandom_range(0, 9));
      e = int'($urandom_range(0, 9));
      send_frame(b, e == 1, e == 0, -1, int'($urandom_range(1, 3)));
      if ($urandom_range(0, 7) == 0) begin
        RX = 1'b0;
        repeat ($urandom_range(1, DIV / 2 - 3)) @(negedge CLK);
        RX = 1'b1;
        repeat (2 * DIV) @(negedge CLK);
      end
    end
    drain();
    check("final_led", 32'(LED), 32'(led_model));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
